// File: rtl/llc_evict_w_master_if.sv
// llc_evict_w_master_if
//   Bundles every handshake/bus signal of llc_evict_w_master. Signal names
//   carry the DUT's point of view (_i = into the block, _o = out of it).
//   Modports:
//     master : used by llc_evict_w_master itself
//     slave  : used by whatever surrounds it (a testbench, the LLC top)
//   Groups: input descriptor, output descriptor, AXI W, AXI B, data-way
//   request, data-way response, flush notification.
//   Optional macro LLC_EVICT_BERR_EN adds b_resp_i and berr_o.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer happens
// on a rising clock edge where valid and ready are both high; a source keeps
// its payload stable while valid is high and ready is low.
interface llc_evict_w_master_if #(
  parameter int NUM_BLOCKS = 4,
  parameter int OFFS_W     = $clog2(NUM_BLOCKS),
  parameter int DATA_W     = 64,
  parameter int INDEX_W    = 8,
  parameter int WAYS       = 4,
  parameter int PAYLOAD_W  = 32
);
  // input descriptor
  logic                 desc_evict_i;
  logic                 desc_flush_i;
  logic [WAYS-1:0]      desc_way_i;
  logic [INDEX_W-1:0]   desc_index_i;
  logic [PAYLOAD_W-1:0] desc_payload_i;
  logic                 desc_valid_i;
  logic                 desc_ready_o;
  // output descriptor
  logic                 desc_evict_o;
  logic                 desc_flush_o;
  logic [WAYS-1:0]      desc_way_o;
  logic [INDEX_W-1:0]   desc_index_o;
  logic [PAYLOAD_W-1:0] desc_payload_o;
  logic                 desc_valid_o;
  logic                 desc_ready_i;
  // AXI W / B
  logic [DATA_W-1:0]    w_data_o;
  logic [DATA_W/8-1:0]  w_strb_o;
  logic                 w_last_o;
  logic                 w_valid_o;
  logic                 w_ready_i;
  logic                 b_valid_i;
  logic                 b_ready_o;
  // data-way request / response
  logic [WAYS-1:0]      way_req_way_o;
  logic [INDEX_W-1:0]   way_req_index_o;
  logic [OFFS_W-1:0]    way_req_offs_o;
  logic                 way_req_valid_o;
  logic                 way_req_ready_i;
  logic [DATA_W-1:0]    way_rsp_data_i;
  logic                 way_rsp_valid_i;
  logic                 way_rsp_ready_o;
  // flush control
  logic                 flush_recv_o;
`ifdef LLC_EVICT_BERR_EN
  logic [1:0]           b_resp_i;
  logic                 berr_o;
`endif

  modport master (
    input  desc_evict_i, desc_flush_i, desc_way_i, desc_index_i, desc_payload_i,
    input  desc_valid_i, desc_ready_i, w_ready_i, b_valid_i, way_req_ready_i,
    input  way_rsp_data_i, way_rsp_valid_i,
`ifdef LLC_EVICT_BERR_EN
    input  b_resp_i,
    output berr_o,
`endif
    output desc_ready_o, desc_evict_o, desc_flush_o, desc_way_o, desc_index_o,
    output desc_payload_o, desc_valid_o, w_data_o, w_strb_o, w_last_o, w_valid_o,
    output b_ready_o, way_req_way_o, way_req_index_o, way_req_offs_o,
    output way_req_valid_o, way_rsp_ready_o, flush_recv_o
  );

  modport slave (
    output desc_evict_i, desc_flush_i, desc_way_i, desc_index_i, desc_payload_i,
    output desc_valid_i, desc_ready_i, w_ready_i, b_valid_i, way_req_ready_i,
    output way_rsp_data_i, way_rsp_valid_i,
`ifdef LLC_EVICT_BERR_EN
    output b_resp_i,
    input  berr_o,
`endif
    input  desc_ready_o, desc_evict_o, desc_flush_o, desc_way_o, desc_index_o,
    input  desc_payload_o, desc_valid_o, w_data_o, w_strb_o, w_last_o, w_valid_o,
    input  b_ready_o, way_req_way_o, way_req_index_o, way_req_offs_o,
    input  way_req_valid_o, way_rsp_ready_o, flush_recv_o
  );
endinterface

// File: rtl/llc_evict_w_master.sv
// llc_evict_w_master
//   Eviction write-beat generator for the LLC refill/eviction path. Takes one
//   descriptor at a time; for an evicting descriptor it reads the whole line
//   from the data ways (one request per block), buffers the beats in a
//   fall-through FIFO of depth NUM_BLOCKS, sends them as one AXI W burst,
//   waits for the B response and then forwards the descriptor. Flush
//   descriptors are dropped at the end with a one-cycle flush_recv pulse.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_i   : synchronous reset, active high
//     bus     : llc_evict_w_master_if.master (all handshake/bus signals)
//     state_o : debug view of the FSM {busy, send}
//   Optional macro LLC_EVICT_BERR_EN: sticky berr_o set by a B handshake
//   with b_resp_i[1]=1 (SLVERR/DECERR); cleared only by reset.
module llc_evict_w_master #(
  parameter int NUM_BLOCKS = 4,
  parameter int OFFS_W     = $clog2(NUM_BLOCKS),
  parameter int DATA_W     = 64,
  parameter int INDEX_W    = 8,
  parameter int WAYS       = 4,
  parameter int PAYLOAD_W  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  llc_evict_w_master_if.master bus,
  output logic [1:0]          state_o
);
  // state bits are {busy, send}
  typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, EVICT = 2'b10, RESP = 2'b11} state_e;

  state_e               state_q, state_d;
  logic                 desc_evict_q, desc_evict_d, desc_flush_q, desc_flush_d;
  logic [WAYS-1:0]      desc_way_q, desc_way_d;
  logic [INDEX_W-1:0]   desc_index_q, desc_index_d;
  logic [PAYLOAD_W-1:0] desc_payload_q, desc_payload_d;
  // MSB of the offset counter is the overflow flag that ends request issue
  logic [OFFS_W:0]      offs_cnt_q, offs_cnt_d;
  logic [OFFS_W-1:0]    len_cnt_q, len_cnt_d;
  logic [DATA_W-1:0]    fifo_mem_q [NUM_BLOCKS];
  logic [OFFS_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OFFS_W:0]      fifo_cnt_q, fifo_cnt_d;
  logic fifo_empty, fifo_full, push, pop;
  logic load_en, desc_valid, flush_recv, b_ready, way_req_valid;

  // ---------------- fall-through FIFO ----------------
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == (OFFS_W+1)'(NUM_BLOCKS));
  assign push       = bus.way_rsp_valid_i & ~fifo_full;
  // A beat pushed into an empty FIFO is visible at the head in the same cycle.
  assign bus.w_valid_o = ~fifo_empty | push;
  assign bus.w_data_o  = fifo_empty ? bus.way_rsp_data_i : fifo_mem_q[rd_ptr_q];
  assign pop           = bus.w_valid_o & bus.w_ready_i;

  // Writing and advancing both pointers even on a bypass keeps them aligned.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + OFFS_W'(push);
    rd_ptr_d   = rd_ptr_q + OFFS_W'(pop);
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + (OFFS_W+1)'(1);
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - (OFFS_W+1)'(1);
  end

  // storage needs no reset: occupancy is tracked by fifo_cnt_q
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= bus.way_rsp_data_i;
  end

  // ---------------- control ----------------
  always_comb begin
    state_d        = state_q;
    desc_evict_d   = desc_evict_q;
    desc_flush_d   = desc_flush_q;
    desc_way_d     = desc_way_q;
    desc_index_d   = desc_index_q;
    desc_payload_d = desc_payload_q;
    offs_cnt_d     = offs_cnt_q;
    len_cnt_d      = len_cnt_q;
    load_en        = 1'b0;
    desc_valid     = 1'b0;
    flush_recv     = 1'b0;
    b_ready        = 1'b0;
    way_req_valid  = 1'b0;
    unique case (state_q)
      IDLE: load_en = 1'b1;
      SEND: begin
        if (desc_flush_q) begin
          flush_recv = 1'b1;
          load_en    = 1'b1;
          state_d    = IDLE;
        end else begin
          desc_valid = 1'b1;
          if (bus.desc_ready_i) begin
            load_en = 1'b1;
            state_d = IDLE;
          end
        end
      end
      EVICT: begin
        way_req_valid = ~offs_cnt_q[OFFS_W];
        if (way_req_valid && bus.way_req_ready_i) offs_cnt_d = offs_cnt_q + (OFFS_W+1)'(1);
        if (pop) len_cnt_d = len_cnt_q - OFFS_W'(1);
        // last beat leaves: accept B in the same cycle if it is already there
        if (pop && len_cnt_q == '0) begin
          b_ready = 1'b1;
          state_d = bus.b_valid_i ? SEND : RESP;
        end
      end
      RESP: begin
        b_ready = 1'b1;
        if (bus.b_valid_i) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
    // Leaving SEND and accepting the next descriptor share one cycle.
    if (load_en && bus.desc_valid_i) begin
      desc_evict_d   = bus.desc_evict_i;
      desc_flush_d   = bus.desc_flush_i;
      desc_way_d     = bus.desc_way_i;
      desc_index_d   = bus.desc_index_i;
      desc_payload_d = bus.desc_payload_i;
      state_d        = bus.desc_evict_i ? EVICT : SEND;
      offs_cnt_d     = '0;
      len_cnt_d      = OFFS_W'(NUM_BLOCKS - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      desc_evict_q   <= 1'b0;
      desc_flush_q   <= 1'b0;
      desc_way_q     <= '0;
      desc_index_q   <= '0;
      desc_payload_q <= '0;
      offs_cnt_q     <= '0;
      len_cnt_q      <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      desc_evict_q   <= desc_evict_d;
      desc_flush_q   <= desc_flush_d;
      desc_way_q     <= desc_way_d;
      desc_index_q   <= desc_index_d;
      desc_payload_q <= desc_payload_d;
      offs_cnt_q     <= offs_cnt_d;
      len_cnt_q      <= len_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
    end
  end

`ifdef LLC_EVICT_BERR_EN
  logic berr_q, berr_d;
  always_comb berr_d = berr_q | (bus.b_valid_i & b_ready & bus.b_resp_i[1]);
  always_ff @(posedge clk_i) begin
    if (rst_i) berr_q <= 1'b0;
    else       berr_q <= berr_d;
  end
  assign bus.berr_o = berr_q;
`endif

  // ---------------- outputs ----------------
  assign state_o             = state_q;
  assign bus.desc_ready_o    = load_en;
  assign bus.desc_valid_o    = desc_valid;
  assign bus.desc_evict_o    = desc_evict_q;
  assign bus.desc_flush_o    = desc_flush_q;
  assign bus.desc_way_o      = desc_way_q;
  assign bus.desc_index_o    = desc_index_q;
  assign bus.desc_payload_o  = desc_payload_q;
  assign bus.w_strb_o        = '1;
  assign bus.w_last_o        = (len_cnt_q == '0);
  assign bus.b_ready_o       = b_ready;
  assign bus.flush_recv_o    = flush_recv;
  assign bus.way_req_valid_o = way_req_valid;
  assign bus.way_req_way_o   = desc_way_q;
  assign bus.way_req_index_o = desc_index_q;
  assign bus.way_req_offs_o  = offs_cnt_q[OFFS_W-1:0];
  assign bus.way_rsp_ready_o = ~fifo_full;
endmodule

// File: tb/tb_llc_evict_w_master.sv
// tb_llc_evict_w_master
//   Directed bench for llc_evict_w_master. A line-level model (expected
//   descriptor queue, expected beat queue, burst/flush bookkeeping) is checked
//   every cycle on the falling edge; inputs change 1 time unit after the
//   rising edge. The bench also acts as the data ways and the AXI B slave.
module tb_llc_evict_w_master;
  localparam int NB = 4, OW = 2, DW = 64, IW = 8, WY = 4, PW = 32;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  llc_evict_w_master_if #(.NUM_BLOCKS(NB), .OFFS_W(OW), .DATA_W(DW), .INDEX_W(IW),
                          .WAYS(WY), .PAYLOAD_W(PW)) bus ();
  logic [1:0] state_o;

  llc_evict_w_master #(.NUM_BLOCKS(NB), .OFFS_W(OW), .DATA_W(DW), .INDEX_W(IW),
                       .WAYS(WY), .PAYLOAD_W(PW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .state_o (state_o)
  );

`ifdef LLC_EVICT_BERR_EN
  initial bus.b_resp_i = 2'b00;
`endif

  // ---------------- scoreboard / model state ----------------
  typedef struct packed {
    logic          evict;
    logic          flush;
    logic [WY-1:0] way;
    logic [IW-1:0] index;
    logic [PW-1:0] payload;
  } desc_t;

  int vectors = 0, miscompares = 0;
  desc_t             exp_desc_q[$];
  logic [DW:0]       exp_q[$];     // {last, data} of each expected W beat
  logic [DW-1:0]     rsp_q[$];     // data-way responses waiting to be driven
  logic [DW-1:0]     w_log[$];     // every W beat seen, for literal checks
  logic [55:0]       rsp_seed = '0;
  bit                m_in_burst = 0, m_awaiting_b = 0, b_arm = 0;
  int                m_req_sent = 0, m_beats = 0, m_flush_pend = 0;
  logic [WY-1:0]     m_way = '0;
  logic [IW-1:0]     m_index = '0;
  int                cyc = 0, b_arm_cyc = 0, b_mode = 0; // b_mode 0: B always ready, 1: B 5 cycles late

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // what the data ways return for block k of the current line
  function automatic logic [DW-1:0] rsp_data(input logic [55:0] seed, input int k);
    logic [7:0] b;
    b = 8'((k + 1) * 17);
    return {seed, b};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin : monitor
    logic w_hs, b_hs, req_hs, rsp_hs, in_hs, out_hs, beat_last;
    logic [DW:0] e;
    desc_t d;
    if (rst_i) begin
      exp_desc_q.delete(); exp_q.delete(); rsp_q.delete();
      m_in_burst = 0; m_awaiting_b = 0; b_arm = 0;
      m_req_sent = 0; m_beats = 0; m_flush_pend = 0;
    end else begin
      w_hs   = bus.w_valid_o & bus.w_ready_i;
      b_hs   = bus.b_valid_i & bus.b_ready_o;
      req_hs = bus.way_req_valid_o & bus.way_req_ready_i;
      rsp_hs = bus.way_rsp_valid_i & bus.way_rsp_ready_o;
      in_hs  = bus.desc_valid_i & bus.desc_ready_o;
      out_hs = bus.desc_valid_o & bus.desc_ready_i;
      beat_last = w_hs && m_in_burst && (m_beats == NB - 1);

      chk("desc_valid_o", 64'(bus.desc_valid_o), 64'(exp_desc_q.size() != 0 && !m_in_burst));
      chk("b_ready_o", 64'(bus.b_ready_o), 64'(m_awaiting_b || beat_last));
      chk("way_req_valid_o", 64'(bus.way_req_valid_o), 64'(m_in_burst && m_req_sent < NB));
      chk("flush_recv_o", 64'(bus.flush_recv_o), 64'(m_flush_pend > 0 && !m_in_burst));

      if (req_hs) begin
        chk("way_req_offs", 64'(bus.way_req_offs_o), 64'(m_req_sent));
        chk("way_req_way", 64'(bus.way_req_way_o), 64'(m_way));
        chk("way_req_index", 64'(bus.way_req_index_o), 64'(m_index));
        rsp_q.push_back(rsp_data(rsp_seed, int'(bus.way_req_offs_o)));
        m_req_sent++;
      end
      if (rsp_hs && rsp_q.size() != 0) void'(rsp_q.pop_front());

      if (w_hs) begin
        w_log.push_back(bus.w_data_o);
        if (exp_q.size() == 0) chk("w_unexpected_beat", 64'(bus.w_data_o), 64'hDEAD);
        else begin
          e = exp_q.pop_front();
          chk("w_data", bus.w_data_o, e[DW-1:0]);
          chk("w_last", 64'(bus.w_last_o), 64'(e[DW]));
          chk("w_strb", 64'(bus.w_strb_o), 64'hFF);
        end
        m_beats++;
        if (beat_last) begin
          if (b_hs) m_in_burst = 0;
          else begin m_awaiting_b = 1; b_arm = 1; b_arm_cyc = cyc; end
        end
      end else if (b_hs && m_awaiting_b) begin
        m_awaiting_b = 0; m_in_burst = 0; b_arm = 0;
      end

      if (out_hs) begin
        if (exp_desc_q.size() == 0) chk("desc_out_unexpected", 64'(bus.desc_payload_o), 64'hDEAD);
        else begin
          d = exp_desc_q.pop_front();
          chk("desc_payload_o", 64'(bus.desc_payload_o), 64'(d.payload));
          chk("desc_index_o", 64'(bus.desc_index_o), 64'(d.index));
          chk("desc_way_o", 64'(bus.desc_way_o), 64'(d.way));
          chk("desc_evict_o", 64'(bus.desc_evict_o), 64'(d.evict));
        end
      end
      if (bus.flush_recv_o && m_flush_pend > 0) m_flush_pend--;

      if (in_hs) begin
        d = '{evict: bus.desc_evict_i, flush: bus.desc_flush_i, way: bus.desc_way_i,
              index: bus.desc_index_i, payload: bus.desc_payload_i};
        if (d.flush) m_flush_pend++;
        else exp_desc_q.push_back(d);
        if (d.evict) begin
          m_in_burst = 1; m_req_sent = 0; m_beats = 0;
          m_way = d.way; m_index = d.index;
          for (int k = 0; k < NB; k++) exp_q.push_back({k == NB - 1, rsp_data(rsp_seed, k)});
        end
      end
    end
  end

  // ---------------- data-way and B responders ----------------
  always @(posedge clk_i) begin
    #1;
    cyc++;
    bus.way_rsp_valid_i = (rsp_q.size() != 0);
    bus.way_rsp_data_i  = (rsp_q.size() != 0) ? rsp_q[0] : '0;
    bus.b_valid_i       = (b_mode == 0) ? 1'b1 : (b_arm && (cyc - b_arm_cyc >= 5));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_i); #1;
  endtask

  task automatic step_drv();
    @(posedge clk_i); #1;
  endtask

  task automatic set_desc(input logic ev, input logic fl, input logic [WY-1:0] w,
                          input logic [IW-1:0] ix, input logic [PW-1:0] pl);
    bus.desc_evict_i = ev; bus.desc_flush_i = fl; bus.desc_way_i = w;
    bus.desc_index_i = ix; bus.desc_payload_i = pl; bus.desc_valid_i = 1'b1;
  endtask

  // returns 1 time unit after the accepting edge
  task automatic send_desc(input logic ev, input logic fl, input logic [WY-1:0] w,
                           input logic [IW-1:0] ix, input logic [PW-1:0] pl);
    bit ok = 0;
    step_drv();
    set_desc(ev, fl, w, ix, pl);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.desc_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("desc_accept_timeout", 64'd0, 64'd1);
    step_drv();
    bus.desc_valid_i = 1'b0;
  endtask

  // what: 0 = burst finished (B taken), 1 = last beat sent, B outstanding
  task automatic wait_model(input int what, input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if ((what == 0 && !m_in_burst) || (what == 1 && m_awaiting_b)) begin ok = 1; break; end
    end
    if (!ok) chk(name, 64'd0, 64'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    int base;
    rst_i = 1'b1;
    bus.desc_evict_i = 0; bus.desc_flush_i = 0; bus.desc_way_i = '0;
    bus.desc_index_i = '0; bus.desc_payload_i = '0; bus.desc_valid_i = 0;
    bus.desc_ready_i = 1; bus.w_ready_i = 1; bus.way_req_ready_i = 1;
    bus.b_valid_i = 0; bus.way_rsp_valid_i = 0; bus.way_rsp_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // reset state
    tick();
    chk("rst_desc_ready", 64'(bus.desc_ready_o), 64'd1);
    chk("rst_desc_valid", 64'(bus.desc_valid_o), 64'd0);
    chk("rst_w_valid", 64'(bus.w_valid_o), 64'd0);
    chk("rst_req_valid", 64'(bus.way_req_valid_o), 64'd0);
    chk("rst_b_ready", 64'(bus.b_ready_o), 64'd0);
    chk("rst_flush_recv", 64'(bus.flush_recv_o), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);

    // plain descriptor is forwarded the next cycle
    send_desc(1'b0, 1'b0, 4'b0001, 8'h05, 32'hA5);
    tick();
    chk("plain_desc_valid", 64'(bus.desc_valid_o), 64'd1);
    chk("plain_payload", 64'(bus.desc_payload_o), 64'hA5);

    // flush descriptor: one-cycle pulse, never forwarded
    send_desc(1'b0, 1'b1, 4'b0001, 8'h06, 32'h77);
    tick();
    chk("flush_pulse", 64'(bus.flush_recv_o), 64'd1);
    chk("flush_desc_valid", 64'(bus.desc_valid_o), 64'd0);
    chk("flush_desc_ready", 64'(bus.desc_ready_o), 64'd1);
    tick();
    chk("flush_pulse_end", 64'(bus.flush_recv_o), 64'd0);

    // eviction, B together with last beat
    rsp_seed = '0; b_mode = 0; bus.desc_ready_i = 0; base = w_log.size();
    send_desc(1'b1, 1'b0, 4'b0010, 8'h12, 32'h3);
    wait_model(0, "evict_burst_timeout");
    tick();
    chk("evict_state_send", 64'(state_o), 64'd1);
    chk("evict_desc_valid", 64'(bus.desc_valid_o), 64'd1);
    chk("evict_beats", 64'(w_log.size() - base), 64'd4);
    chk("evict_beat0", w_log[base], 64'h11);
    chk("evict_beat3", w_log[base + 3], 64'h44);
    step_drv(); bus.desc_ready_i = 1;

    // W stalled for 10 cycles: FIFO fills, nothing lost
    step_drv(); bus.w_ready_i = 0; rsp_seed = 56'h1; base = w_log.size();
    send_desc(1'b1, 1'b0, 4'b0100, 8'h34, 32'h4);
    repeat (10) tick();
    chk("stall_rsp_ready", 64'(bus.way_rsp_ready_o), 64'd0);
    chk("stall_w_valid", 64'(bus.w_valid_o), 64'd1);
    chk("stall_state", 64'(state_o), 64'd2);
    step_drv(); bus.w_ready_i = 1;
    wait_model(0, "stall_burst_timeout");
    chk("stall_beats", 64'(w_log.size() - base), 64'd4);
    chk("stall_beat0", w_log[base], 64'h111);
    chk("stall_beat3", w_log[base + 3], 64'h144);

    // B arrives 5 cycles after the last beat
    step_drv(); b_mode = 1; rsp_seed = 56'h2;
    send_desc(1'b1, 1'b0, 4'b1000, 8'h56, 32'h5);
    wait_model(1, "late_b_last_timeout");
    tick();
    chk("late_b_state_resp", 64'(state_o), 64'd3);
    chk("late_b_ready", 64'(bus.b_ready_o), 64'd1);
    chk("late_b_desc_valid", 64'(bus.desc_valid_o), 64'd0);
    wait_model(0, "late_b_timeout");
    tick();
    chk("late_b_forward", 64'(bus.desc_valid_o), 64'd1);
    step_drv(); b_mode = 0;

    // back-to-back: next descriptor taken in the forwarding cycle
    send_desc(1'b0, 1'b0, 4'b0001, 8'h21, 32'h100);
    set_desc(1'b0, 1'b0, 4'b1000, 8'h22, 32'h200);
    tick();
    chk("b2b_out_valid", 64'(bus.desc_valid_o), 64'd1);
    chk("b2b_in_ready", 64'(bus.desc_ready_o), 64'd1);
    step_drv(); bus.desc_valid_i = 0;
    tick();
    chk("b2b_second_payload", 64'(bus.desc_payload_o), 64'h200);

    // evict + flush: burst, then dropped with a pulse
    rsp_seed = 56'h3;
    send_desc(1'b1, 1'b1, 4'b0001, 8'h78, 32'h6);
    wait_model(0, "evflush_timeout");
    tick();
    chk("evflush_pulse", 64'(bus.flush_recv_o), 64'd1);
    chk("evflush_desc_valid", 64'(bus.desc_valid_o), 64'd0);

    // reset mid-burst abandons it and empties the FIFO
    step_drv(); bus.w_ready_i = 0; rsp_seed = 56'h4;
    send_desc(1'b1, 1'b0, 4'b0010, 8'h9A, 32'h7);
    repeat (3) tick();
    step_drv(); rst_i = 1;
    step_drv(); rst_i = 0; bus.w_ready_i = 1;
    tick();
    chk("midrst_state", 64'(state_o), 64'd0);
    chk("midrst_w_valid", 64'(bus.w_valid_o), 64'd0);
    chk("midrst_desc_ready", 64'(bus.desc_ready_o), 64'd1);
    rsp_seed = 56'h5; base = w_log.size();
    send_desc(1'b1, 1'b0, 4'b0100, 8'hBC, 32'h8);
    wait_model(0, "post_rst_timeout");
    chk("post_rst_beat0", w_log[base], 64'h511);

    repeat (4) tick();
    chk("end_beats_drained", 64'(exp_q.size()), 64'd0);
    chk("end_desc_drained", 64'(exp_desc_q.size()), 64'd0);
    chk("end_flush_drained", 64'(m_flush_pend), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
